// File: rtl/ps2_key_filter.sv
// PS/2 scan-code filter: parses make/break/E0 sequences, folds arrows onto WASD,
// drops typematic repeats and releases buffered key events as single-cycle pulses.
module ps2_key_filter #(
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_byte_valid,
  input  logic [7:0] ps2_byte,
  input  logic       key_ready,
  output logic       key_pressed,
  output logic [7:0] key_data,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e      state_q, state_d;
  logic [25:0] tmo_q, tmo_d;
  logic [7:0]  held_q, held_d;
  logic [7:0]  mem_q [4];
  logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        kp_q, kp_d;
  logic [7:0]  data_q, data_d;
  logic        ovf_q, ovf_d;

  logic        push, push_ok, pop, full;
  logic [7:0]  push_code;
  logic [8:0]  norm_map, ext_map;

  // Returns {valid, code}.
  function automatic logic [8:0] map_normal(input logic [7:0] b);
    unique case (b)
      8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A: return {1'b1, b};
      default:                                  return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] map_ext(input logic [7:0] b);
    unique case (b)
      8'h75:   return {1'b1, 8'h1D};
      8'h72:   return {1'b1, 8'h1B};
      8'h6B:   return {1'b1, 8'h1C};
      8'h74:   return {1'b1, 8'h23};
      default: return 9'h000;
    endcase
  endfunction

  assign norm_map = map_normal(ps2_byte);
  assign ext_map  = map_ext(ps2_byte);

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    tmo_d     = '0;
    push      = 1'b0;
    push_code = '0;
    if (ps2_byte_valid) begin
      unique case (state_q)
        StIdle: begin
          if (ps2_byte == 8'hE0) begin
            state_d = StExt;
          end else if (ps2_byte == 8'hF0) begin
            state_d = StBrk;
          end else if (norm_map[8] && norm_map[7:0] != held_q) begin
            push      = 1'b1;
            push_code = norm_map[7:0];
            held_d    = norm_map[7:0];
          end
        end
        StExt: begin
          if (ps2_byte == 8'hF0) begin
            state_d = StExtBrk;
          end else begin
            state_d = StIdle;
            if (ext_map[8] && ext_map[7:0] != held_q) begin
              push      = 1'b1;
              push_code = ext_map[7:0];
              held_d    = ext_map[7:0];
            end
          end
        end
        StBrk: begin
          state_d = StIdle;
          if (norm_map[8] && norm_map[7:0] == held_q) held_d = '0;
        end
        StExtBrk: begin
          state_d = StIdle;
          if (ext_map[8] && ext_map[7:0] == held_q) held_d = '0;
        end
      endcase
    end else if (state_q != StIdle) begin
      // Abandon a half-received sequence if the keyboard goes quiet.
      if (tmo_q == TIMEOUT_CYCLES - 26'd1) begin
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + 26'd1;
      end
    end
  end

  always_comb begin
    full    = (cnt_q == 3'd4);
    pop     = (cnt_q != 3'd0) && key_ready && !kp_q;
    push_ok = push && !full;
    ovf_d   = ovf_q | (push && full);
    wptr_d  = push_ok ? wptr_q + 2'd1 : wptr_q;
    rptr_d  = pop ? rptr_q + 2'd1 : rptr_q;
    cnt_d   = cnt_q;
    if (push_ok && !pop) cnt_d = cnt_q + 3'd1;
    if (!push_ok && pop) cnt_d = cnt_q - 3'd1;
    kp_d    = pop;
    data_d  = pop ? mem_q[rptr_q] : data_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      held_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      kp_q    <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      kp_q    <= kp_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && push_ok) mem_q[wptr_q] <= push_code;
  end

  assign key_pressed = kp_q;
  assign key_data    = data_q;
  assign fifo_count  = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_filter.sv
// Bench for ps2_key_filter: event-queue reference model compared every cycle,
// plus directed scan-code sequences with literal expectations.
module tb_ps2_key_filter;

  localparam logic [25:0] Tmo = 26'd16;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_byte_valid = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       key_ready = 1'b0;
  logic       key_pressed;
  logic [7:0] key_data;
  logic [2:0] fifo_count;
  logic       overflow;

  ps2_key_filter #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .ps2_byte_valid(ps2_byte_valid),
    .ps2_byte      (ps2_byte),
    .key_ready     (key_ready),
    .key_pressed   (key_pressed),
    .key_data      (key_data),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  int log_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: prefix flags, held key, event queue.
  bit   m_ext = 0, m_brk = 0, m_kp = 0, m_ovf = 0;
  int   m_idle = 0, m_held = 0, m_data = 0;
  int   m_q[$];

  function automatic int nmap(input logic [7:0] b);
    case (b)
      8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A: return int'(b);
      default: return -1;
    endcase
  endfunction

  function automatic int emap(input logic [7:0] b);
    case (b)
      8'h75: return 'h1D;
      8'h72: return 'h1B;
      8'h6B: return 'h1C;
      8'h74: return 'h23;
      default: return -1;
    endcase
  endfunction

  always @(posedge clock) begin
    bit was_full, pop, make;
    int code, rel;
    if (!resetn) begin
      m_ext = 0; m_brk = 0; m_kp = 0; m_ovf = 0;
      m_idle = 0; m_held = 0; m_data = 0;
      m_q.delete();
    end else begin
      was_full = (m_q.size() == 4);
      pop = (m_q.size() > 0) && key_ready && !m_kp;
      make = 0;
      code = -1;
      if (ps2_byte_valid) begin
        m_idle = 0;
        if (m_brk) begin
          rel = m_ext ? emap(ps2_byte) : nmap(ps2_byte);
          if (rel >= 0 && rel == m_held) m_held = 0;
          m_ext = 0; m_brk = 0;
        end else if (ps2_byte == 8'hF0) begin
          m_brk = 1;
        end else if (m_ext) begin
          code = emap(ps2_byte);
          m_ext = 0;
        end else if (ps2_byte == 8'hE0) begin
          m_ext = 1;
        end else begin
          code = nmap(ps2_byte);
        end
        if (code >= 0 && code != m_held) begin
          make = 1;
          m_held = code;
        end
      end else if (m_ext || m_brk) begin
        m_idle++;
        if (m_idle >= int'(Tmo)) begin
          m_ext = 0; m_brk = 0; m_idle = 0;
        end
      end
      if (pop) begin
        m_data = m_q.pop_front();
        m_kp = 1;
      end else begin
        m_kp = 0;
      end
      if (make) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back(code);
      end
    end
  end

  bit prev_kp = 0;
  always @(negedge clock) begin
    if (chk_en) begin
      chk("key_pressed", int'(key_pressed), int'(m_kp));
      chk("key_data", int'(key_data), m_data);
      chk("fifo_count", int'(fifo_count), m_q.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("no_back_to_back", int'(key_pressed && prev_kp), 0);
      if (key_pressed) log_q.push_back(int'(key_data));
    end
    prev_kp = key_pressed;
  end

  task automatic send(input logic [7:0] b);
    ps2_byte = b;
    ps2_byte_valid = 1'b1;
    @(negedge clock);
    ps2_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ps2_byte_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    log_q.delete();
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk_en = 1;
    resetn = 1'b1;

    // Basic make, 2-edge latency.
    do_reset();
    chk("rst_kp", int'(key_pressed), 0);
    chk("rst_data", int'(key_data), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    key_ready = 1'b1;
    send(8'h1D);
    chk("t1_count_after_push", int'(fifo_count), 1);
    chk("t1_kp_not_yet", int'(key_pressed), 0);
    @(negedge clock);
    chk("t1_kp", int'(key_pressed), 1);
    chk("t1_data", int'(key_data), 'h1D);
    chk("t1_count_after_pop", int'(fifo_count), 0);
    idle(3);
    chk("t1_n", log_q.size(), 1);

    // Extended arrow with release in between.
    do_reset();
    key_ready = 1'b1;
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h75);
    idle(4);
    chk("t2_n", log_q.size(), 2);
    chk("t2_d0", log_q[0], 'h1D);
    chk("t2_d1", log_q[1], 'h1D);

    // Typematic suppression and unmapped byte.
    do_reset();
    key_ready = 1'b1;
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C);
    send(8'h2B);
    idle(4);
    chk("t3_n", log_q.size(), 2);
    chk("t3_d0", log_q[0], 'h1C);
    chk("t3_d1", log_q[1], 'h1C);

    // Fill FIFO, overflow, then drain.
    do_reset();
    key_ready = 1'b0;
    send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23); send(8'h29);
    chk("t4_full", int'(fifo_count), 4);
    chk("t4_ovf", int'(overflow), 1);
    key_ready = 1'b1;
    idle(12);
    chk("t4_n", log_q.size(), 4);
    chk("t4_d0", log_q[0], 'h1D);
    chk("t4_d1", log_q[1], 'h1C);
    chk("t4_d2", log_q[2], 'h1B);
    chk("t4_d3", log_q[3], 'h23);
    chk("t4_ovf_sticky", int'(overflow), 1);

    // Timeout after a dangling F0.
    do_reset();
    chk("t5_ovf_cleared", int'(overflow), 0);
    key_ready = 1'b1;
    send(8'hF0);
    idle(20);
    send(8'h1B);
    idle(4);
    chk("t5_n", log_q.size(), 1);
    chk("t5_d0", log_q[0], 'h1B);

    // Reset in EXTBRK with two entries buffered.
    do_reset();
    key_ready = 1'b0;
    send(8'h1D); send(8'h1C);
    send(8'hE0); send(8'hF0);
    chk("t6_count_before", int'(fifo_count), 2);
    resetn = 1'b0;
    @(negedge clock);
    chk("t6_kp", int'(key_pressed), 0);
    chk("t6_data", int'(key_data), 0);
    chk("t6_count", int'(fifo_count), 0);
    chk("t6_ovf", int'(overflow), 0);
    resetn = 1'b1;
    log_q.delete();
    key_ready = 1'b1;
    send(8'h75);
    idle(6);
    chk("t6_n", log_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_filter.md
# ps2_key_filter

Front-end stage between the PS/2 keyboard receiver and the game-logic handshake block. It parses raw scan-code bytes (make, break, E0-extended), folds arrow keys onto W/A/S/D codes and suppresses typematic auto-repeat. Accepted key events are buffered in a 4-entry FIFO and released as single-cycle `key_pressed` pulses with stable `key_data`, which drive the handshake block's `ps2_key_pressed` / `ps2_key_data` inputs.

## Interface
- `TIMEOUT_CYCLES`, default 26'd50_000_000: idle cycles after a prefix byte (E0/F0) before the parser abandons the sequence (1 s at 50 MHz).
- `clock`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `ps2_byte_valid`  in  1  one-cycle strobe from the PS/2 receiver; a new byte is present.
- `ps2_byte`  in  8  received scan-code byte; sampled only when `ps2_byte_valid`=1.
- `key_ready`  in  1  consumer may take an event (high when the position controller is idle).
- `key_pressed`  out  1  one-cycle event pulse.
- `key_data`  out  8  code of the last released event; held between pulses.
- `fifo_count`  out  3  events buffered (0..4).
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO was full.

## Operation
- Parser FSM states: IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0). Transitions occur only on `ps2_byte_valid`, except for the timeout.
  - IDLE: E0→EXT; F0→BRK; any other byte → normal make decode, stay IDLE.
  - EXT: F0→EXTBRK; any other byte → extended make decode, →IDLE.
  - BRK / EXTBRK: byte is a release code; if it equals `held_code` (after mapping), clear `held_code`; →IDLE. No event is produced.
- Normal make map: 1D (W), 1C (A), 1B (S), 23 (D), 29 (space) and 5A (Enter) pass unchanged. All other codes are dropped.
- Extended make map: 75→1D, 72→1B, 6B→1C, 74→23. All other extended codes are dropped.
- Repeat suppression: a mapped make whose code equals `held_code` is dropped. Otherwise it is pushed and `held_code` is set to that code. A release of any other code leaves `held_code` unchanged.
- Timeout: in EXT, BRK or EXTBRK, a 26-bit counter counts cycles without `ps2_byte_valid`. On reaching `TIMEOUT_CYCLES`-1 the FSM returns to IDLE; `held_code` is unchanged. The counter clears on every byte and whenever the FSM is in IDLE.
- FIFO: 4 entries × 8 bits, with 2-bit read/write pointers that wrap 3→0 and a 3-bit count.
  - A push when count==4 is dropped and sets `overflow`. This holds even if a pop happens on the same edge.
  - A simultaneous push and pop with count in 1..3 leaves count unchanged.
- Release: on an edge where count>0, `key_ready`=1 and `key_pressed` is currently 0, pop the head into `key_data` and drive `key_pressed`=1 for exactly one cycle. `key_pressed` is never high on two consecutive cycles.
- Reset (synchronous, any cycle, including mid-sequence): FSM→IDLE, `held_code`=00, pointers, count and timeout counter=0, `key_pressed`=0, `key_data`=00, `overflow`=0, `fifo_count`=0.

## Timing
- Byte sampled at edge k: the FSM state and any push take effect at edge k; the entry is visible in `fifo_count` after edge k.
- Earliest pop is edge k+1, so `key_pressed` is high in the cycle after edge k+1. Latency is 2 edges from the byte strobe to the pulse.
- Maximum release rate is one event per 2 cycles.
- `key_ready` is sampled only at the pop edge; deasserting it later does not cancel a pulse already issued.
- `key_data` changes only on a pop edge.
- `overflow` clears only on reset.

## Test plan
- Reset then byte 1D with `key_ready`=1 → `key_pressed` pulses 2 edges later with `key_data`=1D; `fifo_count` goes 1→0.
- E0 75, then E0 F0 75, then E0 75 → two pulses, both with `key_data`=1D; the release produces no pulse.
- 1C, 1C, 1C (typematic), then F0 1C, then 1C → exactly two pulses with 1C; a 2B byte produces no pulse.
- `key_ready`=0; send 1D, 1C, 1B, 23, 29 → `fifo_count`=4 and `overflow`=1. Raise `key_ready` → pulses 1D, 1C, 1B, 23, each separated by ≥1 low cycle.
- F0 followed by no byte for `TIMEOUT_CYCLES` (set to 16 for simulation), then 1B → pulse with 1B; the 1B is not consumed as a release.
- Assert reset while in EXTBRK with 2 entries buffered → all outputs 0 on the next cycle; a subsequent 75 (no prefix) produces no event.
